// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_pkg : shared state encoding and default 640x480@60 raster timing       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package vga_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int CNT_W     = 10;
    localparam int MAX_TOTAL = 1 << CNT_W;

    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BP        = 48;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_V_FP        = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BP        = 33;
    localparam int DEF_LOCK_SETTLE = 1024;

    function automatic int span_total(input int active, input int fp, input int sync_w, input int bp);
        return active + fp + sync_w + bp;
    endfunction

    // Sync window is [sync_begin, sync_end) in counter units.
    function automatic int sync_begin(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_end(input int active, input int fp, input int sync_w);
        return active + fp + sync_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_lock_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_lock_sync : 2-flop synchronizer for PLL lock plus settle counter       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vga_lock_sync
    import vga_pkg::*;
#(
    parameter int LOCK_SETTLE = DEF_LOCK_SETTLE
) (
    input  logic clk,
    input  logic rst,
    input  logic locked,
    input  logic settling,
    output logic lk_s,
    output logic lock_ok
);

    localparam int SW = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_SETTLE - 1);

    logic          sync1;
    logic          sync2;
    logic [SW-1:0] settle_cnt;

    generate
        if (LOCK_SETTLE < 1) begin : g_bad_settle
            $error("vga_lock_sync: LOCK_SETTLE must be at least 1");
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            settle_cnt <= '0;
        end else begin
            sync1 <= locked;
            sync2 <= sync1;
            // Counter only advances while the FSM sits in SETTLE; any exit restarts it.
            if (settling) begin
                settle_cnt <= settle_cnt + SW'(1);
            end else begin
                settle_cnt <= '0;
            end
        end
    end

    assign lk_s    = sync2;
    assign lock_ok = settling && sync2 && (settle_cnt == SETTLE_LAST);

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_timing_gen : VGA raster timing with PLL-lock gated start               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int LOCK_SETTLE = DEF_LOCK_SETTLE
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             locked,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start,
    output logic             running
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int XW      = CNT_W + 1;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [XW-1:0]    H_ACT_E  = XW'(H_ACTIVE);
    localparam logic [XW-1:0]    V_ACT_E  = XW'(V_ACTIVE);
    localparam logic [XW-1:0]    HS_BEG_E = XW'(sync_begin(H_ACTIVE, H_FP));
    localparam logic [XW-1:0]    HS_END_E = XW'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [XW-1:0]    VS_BEG_E = XW'(sync_begin(V_ACTIVE, V_FP));
    localparam logic [XW-1:0]    VS_END_E = XW'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_timing
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
        end
    endgenerate

    state_t           state;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic [XW-1:0]    h_ext;
    logic [XW-1:0]    v_ext;
    logic             lk_s;
    logic             lock_ok;

    assign h_ext   = {1'b0, hcnt};
    assign v_ext   = {1'b0, vcnt};
    assign running = (state == RUN);

    vga_lock_sync #(
        .LOCK_SETTLE (LOCK_SETTLE)
    ) u_lock_sync (
        .clk      (clkin),
        .rst      (rst),
        .locked   (locked),
        .settling (state == SETTLE),
        .lk_s     (lk_s),
        .lock_ok  (lock_ok)
    );

    always_ff @(posedge clkin) begin
        if (!rst) begin
            state       <= WAIT_LOCK;
            hcnt        <= '0;
            vcnt        <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    hcnt <= '0;
                    vcnt <= '0;
                    if (lk_s) state <= SETTLE;
                end
                SETTLE: begin
                    hcnt <= '0;
                    vcnt <= '0;
                    if (!lk_s) begin
                        state <= WAIT_LOCK;
                    end else if (lock_ok) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!lk_s) begin
                        state <= WAIT_LOCK;
                        hcnt  <= '0;
                        vcnt  <= '0;
                    end else if (hcnt == H_LAST) begin
                        hcnt <= '0;
                        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CNT_W'(1);
                    end else begin
                        hcnt <= hcnt + CNT_W'(1);
                    end
                end
                default: state <= WAIT_LOCK;
            endcase

            // Decode lags the counters by one cycle and keys off the current state,
            // so a lock loss idles the outputs on the cycle after leaving RUN.
            if (state == RUN) begin
                de          <= (h_ext < H_ACT_E) && (v_ext < V_ACT_E);
                hsync       <= (h_ext >= HS_BEG_E && h_ext < HS_END_E) ? HS_POL : ~HS_POL;
                vsync       <= (v_ext >= VS_BEG_E && v_ext < VS_END_E) ? VS_POL : ~VS_POL;
                x           <= hcnt;
                y           <= vcnt;
                line_start  <= (hcnt == '0);
                frame_start <= (hcnt == '0) && (vcnt == '0);
            end else begin
                de          <= 1'b0;
                hsync       <= ~HS_POL;
                vsync       <= ~VS_POL;
                x           <= '0;
                y           <= '0;
                line_start  <= 1'b0;
                frame_start <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
